// File: rtl/totp_pkg.sv
// Shared types and helpers for the TOTP truncation stage: state encoding,
// per-DIGITS modulo/BCD sizing, and digest byte addressing.
package totp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRUNC = 2'd1,
    MOD   = 2'd2,
    BCD   = 2'd3
  } state_t;

  function automatic int mod_value(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v;
  endfunction

  // Restoring steps so that M << (steps-1) still covers any 31-bit value.
  function automatic int mod_steps(input int digits);
    case (digits)
      7:       return 8;
      8:       return 5;
      default: return 12;
    endcase
  endfunction

  function automatic int bin_bits(input int digits);
    case (digits)
      7:       return 24;
      8:       return 27;
      default: return 20;
    endcase
  endfunction

  // Byte 0 is the most significant byte of the digest.
  function automatic logic [7:0] digest_byte(input logic [159:0] d, input logic [4:0] idx);
    return d[159 - 8 * int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/totp_bin2bcd.sv
// Sequential double-dabble: BIN_BITS shift edges after start, result held
// in bcd and announced by a one-cycle done pulse.
module totp_bin2bcd #(
  parameter int BIN_BITS = 20,
  parameter int DIGITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_BITS-1:0]   bin,
  output logic                  last,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  logic                active;
  logic [BIN_BITS-1:0] bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] bcd_shift;
  logic [4:0]          cnt;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {adj[4*DIGITS-2:0], bin_q[BIN_BITS-1]};
    last      = active && (cnt == 5'(BIN_BITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      bcd    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active <= 1'b1;
        bin_q  <= bin;
        bcd_q  <= '0;
        cnt    <= '0;
      end else if (active) begin
        bcd_q <= bcd_shift;
        bin_q <= bin_q << 1;
        cnt   <= cnt + 5'd1;
        if (last) begin
          active <= 1'b0;
          done   <= 1'b1;
          bcd    <= bcd_shift;
        end
      end
    end
  end

endmodule

// File: rtl/totp_truncate.sv
// RFC 4226 dynamic truncation, restoring mod 10^DIGITS, then BCD conversion.
// Optional sticky overrun flag under `define TOTP_TRUNC_OVERRUN_EN.
module totp_truncate
  import totp_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_init,
  input  logic [159:0]        digest,
  output logic                sample_ready,
  output logic [4*DIGITS-1:0] sample_output,
  output logic                busy,
`ifdef TOTP_TRUNC_OVERRUN_EN
  output logic                overrun,
`endif
  output logic [1:0]          dbg_state
);

  localparam int MSTEPS = mod_steps(DIGITS);
  localparam int BBITS  = bin_bits(DIGITS);
  localparam int PW     = 31 + MSTEPS;
  localparam logic [PW-1:0] MVAL = PW'(mod_value(DIGITS));

  // Handshake: a request is accepted only on an edge where sample_init=1 and
  // state is IDLE; sample_ready pulses once and sample_output holds after it.
  state_t         state, state_nx;
  logic [159:0]   digest_q;
  logic [PW-1:0]  p_q;
  logic [3:0]     k_q;
  logic [PW-1:0]  m_shift;
  logic [PW-1:0]  p_step;
  logic [31:0]    p_trunc;
  logic [7:0]     b0, b1, b2, b3;
  logic [3:0]     off;
  logic           accept;
  logic           b2b_start;
  logic           b2b_last;

  assign accept    = (state == IDLE) && sample_init;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign b2b_start = (state == MOD) && (k_q == 4'd0);

  always_comb begin
    off     = digest_q[3:0];
    b0      = digest_byte(digest_q, {1'b0, off});
    b1      = digest_byte(digest_q, {1'b0, off} + 5'd1);
    b2      = digest_byte(digest_q, {1'b0, off} + 5'd2);
    b3      = digest_byte(digest_q, {1'b0, off} + 5'd3);
    p_trunc = {b0, b1, b2, b3} & 32'h7FFF_FFFF;
    m_shift = MVAL << k_q;
    p_step  = (p_q >= m_shift) ? (p_q - m_shift) : p_q;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_init) state_nx = TRUNC;
      TRUNC:   state_nx = MOD;
      MOD:     if (k_q == 4'd0) state_nx = BCD;
      BCD:     if (b2b_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      digest_q <= '0;
      p_q      <= '0;
      k_q      <= '0;
    end else begin
      state <= state_nx;
      if (accept) digest_q <= digest;
      if (state == TRUNC) begin
        p_q <= PW'(p_trunc);
        k_q <= 4'(MSTEPS - 1);
      end else if (state == MOD) begin
        p_q <= p_step;
        if (k_q != 4'd0) k_q <= k_q - 4'd1;
      end
    end
  end

`ifdef TOTP_TRUNC_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      overrun <= 1'b0;
    else if (sample_init && busy) overrun <= 1'b1;
    else if (accept)              overrun <= 1'b0;
  end
`endif

  // The converter loads the final remainder on the last MOD edge.
  totp_bin2bcd #(
    .BIN_BITS (BBITS),
    .DIGITS   (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (b2b_start),
    .bin   (p_step[BBITS-1:0]),
    .last  (b2b_last),
    .done  (sample_ready),
    .bcd   (sample_output)
  );

endmodule
